icache_refill: RTL

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: queues missing lines, fetches them beat by beat, fills the cache.
// Define ICACHE_REFILL_DEDUP_EN to suppress misses whose line is already in flight, queued, or duplicated across ports.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module icache_refill #(
  parameter int LINE_SIZE    = 2,
  parameter int MISS_Q_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [`ADDR_WIDTH-1:0]       miss_addr [2],
  input  logic [1:0]                   miss,
  input  logic                         ext_flush,
  output logic                         mem_req_valid,
  output logic [`ADDR_WIDTH-1:0]       mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [31:0]                  mem_resp_data,
  output logic                         fetch_addr_valid,
  output logic [`ADDR_WIDTH-1:0]       fetch_addr,
  output logic [32*LINE_SIZE-1:0]      fetched_data,
  output logic                         busy,
  output logic                         queue_full
);

  localparam int AW     = `ADDR_WIDTH;
  localparam int OFF_W  = 2 + $clog2(LINE_SIZE);
  localparam int BEAT_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int PTR_W  = $clog2(MISS_Q_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(MISS_Q_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COLLECT, S_FILL} state_e;

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    line_of = {a[AW-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  state_e                  state_q, state_d;
  logic [AW-1:0]           cur_line_q, cur_line_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    drop_q, drop_d;
  logic [32*LINE_SIZE-1:0] data_q, data_d;

  logic [AW-1:0]           q_mem [MISS_Q_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_1;
  logic [CNT_W-1:0]        count_q, count_d, free_slots;

  logic                    deq;
  logic [AW-1:0]           line0, line1;
  logic                    dup0, dup1, enq0, enq1;
  logic [1:0]              n_enq;

  assign line0 = line_of(miss_addr[0]);
  assign line1 = line_of(miss_addr[1]);

  // Duplicate detection: only a live (not dropped) in-flight line counts, since a
  // dropped refill never fills the cache.
`ifdef ICACHE_REFILL_DEDUP_EN
  logic             hit0, hit1;
  logic [PTR_W-1:0] offs;
  always_comb begin
    hit0 = (state_q != S_IDLE) && !drop_q && (line0 == cur_line_q);
    hit1 = (state_q != S_IDLE) && !drop_q && (line1 == cur_line_q);
    offs = '0;
    for (int k = 0; k < MISS_Q_DEPTH; k++) begin
      offs = PTR_W'(k) - rd_ptr_q;
      if ({1'b0, offs} < count_q) begin
        if (q_mem[k] == line0) hit0 = 1'b1;
        if (q_mem[k] == line1) hit1 = 1'b1;
      end
    end
    dup0 = hit0;
    dup1 = hit1 || (miss[0] && (line0 == line1));
  end
`else
  assign dup0 = 1'b0;
  assign dup1 = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    cur_line_d       = cur_line_q;
    beat_d           = beat_q;
    drop_d           = drop_q;
    data_d           = data_q;
    deq              = 1'b0;
    mem_req_valid    = 1'b0;
    fetch_addr_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !ext_flush) begin
          deq        = 1'b1;
          cur_line_d = q_mem[rd_ptr_q];
          drop_d     = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (ext_flush) drop_d = 1'b1;
        if (mem_req_ready) begin
          beat_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (ext_flush) drop_d = 1'b1;
        if (mem_resp_valid) begin
          data_d[32*beat_q +: 32] = mem_resp_data;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = (drop_q || ext_flush) ? S_IDLE : S_FILL;
          end
        end
      end
      S_FILL: begin
        fetch_addr_valid = !drop_q && !ext_flush;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue bookkeeping; a same-cycle dequeue frees its slot for the incoming misses.
  always_comb begin
    free_slots = DEPTH_C - count_q + CNT_W'(deq);
    enq0       = miss[0] && !dup0 && !ext_flush && (free_slots != '0);
    enq1       = miss[1] && !dup1 && !ext_flush &&
                 (free_slots >= (enq0 ? CNT_W'(2) : CNT_W'(1)));
    n_enq      = {1'b0, enq0} + {1'b0, enq1};
    wr_ptr_1   = wr_ptr_q + PTR_W'(enq0);
    if (ext_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = count_q + CNT_W'(n_enq) - CNT_W'(deq);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_line_q <= '0;
      beat_q     <= '0;
      drop_q     <= 1'b0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_line_q <= cur_line_d;
      beat_q     <= beat_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (enq0) q_mem[wr_ptr_q] <= line0;
    if (enq1) q_mem[wr_ptr_1] <= line1;
  end

  assign mem_req_addr = cur_line_q;
  assign fetch_addr   = cur_line_q;
  assign fetched_data = data_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign queue_full   = (count_q == DEPTH_C);

endmodule
